// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises rx, validates the start bit, samples bit centres
// with a 3-sample majority vote and emits bytes with a one-cycle strobe.
module uart_rx_deframer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   live_q;
    logic                   rx_prev_q;
    logic [2:0]             maj_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             idx_q;
    logic [7:0]             shreg_q;
    logic [7:0]             rx_data_q;
    logic                   new_rx_data_q;
    logic                   frame_err_q;
    logic                   busy_q;

    logic rx_s;
    logic maj;
    logic line_live;

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign maj  = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
    // Edge detection only trusts rx_s/rx_prev once real pin samples have replaced the reset ones,
    // so a line held low through reset never looks like a start edge.
    assign line_live = live_q[SYNC_STAGES];

    assign rx_data     = rx_data_q;
    assign new_rx_data = new_rx_data_q;
    assign frame_err   = frame_err_q;
    assign busy        = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync_q        <= '1;
            live_q        <= '0;
            rx_prev_q     <= 1'b1;
            maj_q         <= 3'b111;
            cnt_q         <= '0;
            idx_q         <= '0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], rx};
            live_q        <= {live_q[SYNC_STAGES-1:0], 1'b1};
            rx_prev_q     <= rx_s;
            maj_q         <= {maj_q[1:0], rx_s};
            new_rx_data_q <= 1'b0;
            frame_err_q   <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (line_live && rx_prev_q && !rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (!maj) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        shreg_q <= {maj, shreg_q[7:1]};
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Leave at the stop-bit centre so a back-to-back start edge is not missed.
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (maj) begin
                            rx_data_q     <= shreg_q;
                            new_rx_data_q <= 1'b1;
                            state_q       <= S_IDLE;
                            busy_q        <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: one instance at 16 clks/bit, one at 100 clks/bit
// for transmitter rate-error cases.
module tb_uart_rx_deframer;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx100;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       frame_err;
    logic       busy;
    logic [7:0] rx_data100;
    logic       new_rx_data100;
    logic       frame_err100;
    logic       busy100;

    int n_checks = 0;
    int n_err    = 0;

    int n_new     = 0;
    int n_ferr    = 0;
    int n_both    = 0;
    int n_new100  = 0;
    int n_ferr100 = 0;
    logic [7:0] got_q[$];

    uart_rx_deframer #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .new_rx_data(new_rx_data),
        .frame_err(frame_err), .busy(busy)
    );

    uart_rx_deframer #(.CLKS_PER_BIT(100), .SYNC_STAGES(2)) dut100 (
        .clk(clk), .rst(rst), .rx(rx100),
        .rx_data(rx_data100), .new_rx_data(new_rx_data100),
        .frame_err(frame_err100), .busy(busy100)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (new_rx_data) begin
            n_new <= n_new + 1;
            got_q.push_back(rx_data);
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (new_rx_data && frame_err) n_both <= n_both + 1;
        if (new_rx_data100) n_new100 <= n_new100 + 1;
        if (frame_err100) n_ferr100 <= n_ferr100 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input logic v, input bit on100);
        if (on100) rx100 = v;
        else rx = v;
    endtask

    task automatic drive_bit(input logic v, input int period, input bit glitch, input bit on100);
        set_line(v, on100);
        if (glitch) begin
            repeat (period / 2) @(negedge clk);
            set_line(~v, on100);
            @(negedge clk);
            set_line(v, on100);
            repeat (period - period / 2 - 1) @(negedge clk);
        end else begin
            repeat (period) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int period, input logic stop_bit,
                             input bit glitch, input bit on100);
        drive_bit(1'b0, period, 1'b0, on100);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period, glitch, on100);
        drive_bit(stop_bit, period, 1'b0, on100);
    endtask

    initial begin
        int base_new;
        int base_ferr;
        int base_q;
        int lat;
        bit found;
        int busy_cnt;

        rst   = 1'b1;
        rx    = 1'b1;
        rx100 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_new", 32'(new_rx_data), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        repeat (10) @(negedge clk);

        // Single byte, latency from pin start edge.
        base_new = n_new; base_ferr = n_ferr; base_q = got_q.size();
        lat = 0; found = 1'b0;
        fork
            send_byte(8'h72, 16, 1'b1, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 200 && !found; k++) begin
                    @(negedge clk);
                    lat++;
                    if (new_rx_data) found = 1'b1;
                end
            end
        join
        repeat (10) @(negedge clk);
        check("t1_found", 32'(found), 32'h1);
        check("t1_latency_window", 32'(lat >= 155 && lat <= 157), 32'h1);
        check("t1_pulses", 32'(n_new - base_new), 32'd1);
        check("t1_data", 32'(rx_data), 32'h72);
        check("t1_ferr", 32'(n_ferr - base_ferr), 32'd0);

        // Back-to-back "sgi".
        base_new = n_new; base_ferr = n_ferr; base_q = got_q.size();
        send_byte(8'h73, 16, 1'b1, 1'b0, 1'b0);
        send_byte(8'h67, 16, 1'b1, 1'b0, 1'b0);
        send_byte(8'h69, 16, 1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("t2_pulses", 32'(n_new - base_new), 32'd3);
        check("t2_ferr", 32'(n_ferr - base_ferr), 32'd0);
        if (got_q.size() >= base_q + 3) begin
            check("t2_byte0", 32'(got_q[base_q]), 32'h73);
            check("t2_byte1", 32'(got_q[base_q + 1]), 32'h67);
            check("t2_byte2", 32'(got_q[base_q + 2]), 32'h69);
        end else begin
            check("t2_queue_len", 32'(got_q.size() - base_q), 32'd3);
        end

        // Short low glitch on an idle line.
        base_new = n_new; base_ferr = n_ferr;
        busy_cnt = 0;
        rx = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 4) rx = 1'b1;
            if (busy) busy_cnt++;
        end
        check("t3_busy_bounded", 32'(busy_cnt >= 1 && busy_cnt <= 8), 32'h1);
        check("t3_no_new", 32'(n_new - base_new), 32'd0);
        check("t3_no_ferr", 32'(n_ferr - base_ferr), 32'd0);

        // Framing error followed by a held-low break.
        base_new = n_new; base_ferr = n_ferr;
        send_byte(8'h55, 16, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        check("t4_busy_in_break", 32'(busy), 32'h1);
        check("t4_one_ferr", 32'(n_ferr - base_ferr), 32'd1);
        check("t4_no_new", 32'(n_new - base_new), 32'd0);
        check("t4_data_held", 32'(rx_data), 32'h69);
        rx = 1'b1;
        @(negedge clk);
        check("t4_busy_until_release", 32'(busy), 32'h1);
        repeat (5) @(negedge clk);
        check("t4_busy_after_release", 32'(busy), 32'h0);
        repeat (10) @(negedge clk);
        base_new = n_new;
        send_byte(8'h41, 16, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t4_next_pulse", 32'(n_new - base_new), 32'd1);
        check("t4_next_data", 32'(rx_data), 32'h41);
        check("t4_ferr_total", 32'(n_ferr - base_ferr), 32'd1);

        // Reset in the middle of data bit 4 of 0xA5; line still low out of reset.
        base_new = n_new; base_ferr = n_ferr;
        drive_bit(1'b0, 16, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1, 16, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_data", 32'(rx_data), 32'h00);
        check("t5_rst_new", 32'(new_rx_data), 32'h0);
        check("t5_rst_ferr", 32'(frame_err), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 7) rx = 1'b1;
            if (busy) busy_cnt++;
        end
        check("t5_no_start_from_low", 32'(busy_cnt), 32'd0);
        check("t5_no_strobe", 32'(n_new - base_new), 32'd0);
        send_byte(8'h0F, 16, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("t5_next_data", 32'(rx_data), 32'h0F);
        check("t5_next_pulse", 32'(n_new - base_new), 32'd1);

        // Single-clock glitches at data bit centres.
        base_new = n_new; base_ferr = n_ferr;
        send_byte(8'hC3, 16, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("t6_glitch_data", 32'(rx_data), 32'hC3);
        check("t6_glitch_pulse", 32'(n_new - base_new), 32'd1);
        check("t6_glitch_ferr", 32'(n_ferr - base_ferr), 32'd0);

        // Transmitter rate error of -3% and +3% at 100 clks/bit.
        base_new = n_new100; base_ferr = n_ferr100;
        send_byte(8'hC3, 97, 1'b1, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("t6_fast_data", 32'(rx_data100), 32'hC3);
        check("t6_fast_pulse", 32'(n_new100 - base_new), 32'd1);
        send_byte(8'h3C, 103, 1'b1, 1'b0, 1'b1);
        repeat (60) @(negedge clk);
        check("t6_slow_data", 32'(rx_data100), 32'h3C);
        check("t6_slow_pulse", 32'(n_new100 - base_new), 32'd2);
        check("t6_rate_ferr", 32'(n_ferr100 - base_ferr), 32'd0);

        check("never_both_strobes", 32'(n_both), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
